// File: rtl/fetch_buffer.sv
// Instruction prefetch queue: issues one memory read at a time and buffers returned words
// with their PCs until the consumer pops them.
module fetch_buffer #(
    parameter int ADDR_W = 23,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic                         data_req,
    output logic                         mem_ce,
    output logic [31:0]                  mem_addr,
    input  logic                         mem_busy,
    input  logic                         mem_valid,
    input  logic [31:0]                  mem_data,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [31:0]                  instr,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [1:0]                   fsm_state
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(3);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   ipc_q, ipc_d;
    logic [PTR_W-1:0]    rd_q, rd_d;
    logic [PTR_W-1:0]    wr_q, wr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [31:0]         data_mem_q [DEPTH];
    logic [31:0]         data_mem_d [DEPTH];
    logic [ADDR_W-1:0]   pc_mem_q [DEPTH];
    logic [ADDR_W-1:0]   pc_mem_d [DEPTH];

    logic pop;
    logic push;
    logic has_room;
    logic issue;

    // The head transfers on any cycle with instr_valid && instr_ready; instr/instr_pc
    // stay put until that happens. A redirect in the same cycle cancels the pop.
    assign pop      = (level_q != '0) && instr_ready && !redirect;
    assign push     = (state_q == S_WAIT) && mem_valid && !redirect;
    assign has_room = (level_q != LVL_W'(DEPTH)) || pop;
    // mem_valid is deliberately absent here: a returning word only frees IDLE next cycle.
    assign issue    = !reset && (state_q == S_IDLE) && !redirect && !data_req
                      && !mem_busy && has_room;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ipc_d      = ipc_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        level_d    = level_q;
        data_mem_d = data_mem_q;
        pc_mem_d   = pc_mem_q;

        if (redirect) begin
            pc_d    = redirect_pc & ~ALIGN_MASK;
            rd_d    = '0;
            wr_d    = '0;
            level_d = '0;
            // An outstanding read must still be absorbed unless it is returning right now.
            if (state_q != S_IDLE) begin
                state_d = mem_valid ? S_IDLE : S_DISCARD;
            end
        end else begin
            if (issue) begin
                ipc_d   = pc_q;
                pc_d    = pc_q + ADDR_W'(4);
                state_d = S_WAIT;
            end
            if ((state_q == S_WAIT || state_q == S_DISCARD) && mem_valid) begin
                state_d = S_IDLE;
            end
            if (push) begin
                data_mem_d[wr_q] = mem_data;
                pc_mem_d[wr_q]   = ipc_q;
                wr_d             = wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ipc_q      <= ipc_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            level_q    <= level_d;
            data_mem_q <= data_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

    assign mem_ce      = issue;
    assign mem_addr    = issue ? 32'(pc_q) : 32'd0;
    assign instr_valid = !reset && (level_q != '0);
    assign instr       = instr_valid ? data_mem_q[rd_q] : 32'd0;
    assign instr_pc    = instr_valid ? pc_mem_q[rd_q] : '0;
    assign level       = reset ? '0 : level_q;
    assign fsm_state   = state_q;

endmodule
